flag_gen: RTL
=============

# flag_gen

Condition-flag generator and flag register for the SIMPLE core: the producer of the 4-bit `{S,Z,C,V}` condition bus that the branch-decision logic consumes. It takes each executed ALU/shift instruction, computes its flags, and commits them to an architectural flag register through a two-stage pipeline. While a flag update is in flight it raises `busy`, so the branch side waits for committed flags.

## Interface
Parameters:
- `W`, default 16: datapath width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  an executed instruction is presented this cycle.
- `op`  in  4  SIMPLE opcode field.
- `a`  in  W  operand Rd.
- `b`  in  W  operand Rs, or shift amount (`b[3:0]`).
- `result`  in  W  ALU/shifter result for this instruction.
- `stall`  in  1  freeze the whole block.
- `flush`  in  1  cancel the in-flight update.
- `cond`  out  4  committed flags `{S,Z,C,V}` (bit 3 = S).
- `busy`  out  1  a flag-writing op is in stage 1 and not yet committed.

## Operation
- Flag-writing ops: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, CMP 0101, MOV 0110, SLL 1000, SLR 1001, SRL 1010, SRA 1011. All other opcodes (IN, OUT, HLT, reserved) are not accepted into stage 1 and leave `cond` untouched.
- Stage 0 (accept): when `in_valid & flag-writing op & !stall & !flush`, capture `op`, `a`, `b` and `result` into stage 1 and set the stage-1 valid bit.
- Stage 1 (commit): when stage 1 is valid, `!stall` and `!flush`, compute the flags and load them into `cond`. A new op may be accepted on the same edge (back-to-back throughput of 1 per cycle).
- S = `result[W-1]`; Z = (`result == 0`), for all flag-writing ops.
- ADD: C = carry-out of `a+b` (W+1-bit sum); V = signed overflow (operands have the same sign and the result sign differs).
- SUB, CMP: C = borrow (`a < b` unsigned); V = signed overflow of `a-b`. CMP differs from SUB only in the datapath; here it is handled identically.
- AND, OR, XOR, MOV: C = 0, V = 0.
- Shifts, with n = `b[3:0]`; if n = 0 then C = 0:
  - SLL: C = `a[W-n]`, the last bit shifted out.
  - SRL, SRA: C = `a[n-1]`.
  - SLR (rotate): C = 0.
  - All shifts: V = 0.
- `stall`: stage 1 and `cond` hold; no accept, no commit.
- `flush`: has priority over `stall`. Stage-1 valid clears on the edge; no commit that cycle; the input presented that cycle is dropped. `cond` is unchanged.
- `busy` = stage-1 valid, driven from the register (no combinational path from inputs).

## Timing
- Reset: `cond` = 4'b0000, `busy` = 0, stage-1 valid = 0. Reset takes effect immediately, including mid-operation; an in-flight op is discarded.
- Latency: op accepted in cycle t → `busy` = 1 in cycle t+1 → new `cond` visible in cycle t+2 (no stall).
- Back-to-back ops at t and t+1 → `cond` updates at t+2 and t+3; `busy` stays high during t+1 and t+2.
- Stall for k cycles while `busy` = 1 → commit is delayed by k cycles; `busy` stays high throughout.
- Non-flag op accepted while the previous op commits → `busy` drops the following cycle.

## Structure
- Shared package `simple_pkg`:
  - opcode constants `OP_ADD` … `OP_SRA`;
  - flag bit indices `FLG_S=3, FLG_Z=2, FLG_C=1, FLG_V=0`;
  - helper `is_flag_op(op)`.
- Sub-module `flag_calc`: purely combinational computation of (op, a, b, result) → `{S,Z,C,V}`, instantiated in stage 1. `flag_gen` holds the pipeline register, control logic and flag register.

## Test plan
- Reset mid-op: assert `rst_n` = 0 while `busy` = 1 → `cond` = 0000 and `busy` = 0 immediately; no later commit.
- ADD a=0x7FFF, b=0x0001, result=0x8000 → `cond` = 1001 two cycles later; `busy` = 1 in the intervening cycle.
- SUB 0x0005−0x0005 → `cond` = 0100; then CMP a=0x0003, b=0x0005, result=0xFFFE → `cond` = 1010.
- SLL a=0x8001, n=1, result=0x0002 → `cond` = 0010. SRA a=0x8001, n=1, result=0xC000 → `cond` = 1010. SLL with n=0 → C = 0.
- ADD committing to 0100, then `stall` held 3 cycles while `busy` → `cond` holds its old value for 3 extra cycles, then becomes 0100. Repeat with `flush` instead of `stall` → `cond` never changes and `busy` = 0 the next cycle.
- Back-to-back AND (result 0) then OUT then XOR (result 0x8000) → `cond` = 0100 then 1000; OUT causes no update.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core: opcodes, condition-flag bit positions
// and the opcode classification used by the flag generator.
package simple_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // How C and V are formed for a given opcode.
    typedef enum logic [2:0] {
        FC_NONE,
        FC_ADD,
        FC_SUB,
        FC_LOGIC,
        FC_SHL,
        FC_SHR,
        FC_ROT
    } flag_class_e;

    function automatic flag_class_e flag_class(input logic [3:0] op);
        flag_class_e cls;
        case (op)
            OP_ADD:                         cls = FC_ADD;
            OP_SUB, OP_CMP:                 cls = FC_SUB;
            OP_AND, OP_OR, OP_XOR, OP_MOV:  cls = FC_LOGIC;
            OP_SLL:                         cls = FC_SHL;
            OP_SRL, OP_SRA:                 cls = FC_SHR;
            OP_SLR:                         cls = FC_ROT;
            default:                        cls = FC_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic is_flag_op(input logic [3:0] op);
        return flag_class(op) != FC_NONE;
    endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational condition-flag computation {S,Z,C,V} for one executed
// instruction, given its opcode, operands and the datapath result.
module flag_calc
    import simple_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] result,
    output logic [3:0]   flags
);

    logic [3:0] shamt;
    logic       sign_a;
    logic       sign_b;
    logic       sign_r;
    logic       shl_out;
    logic       shr_out;
    logic       carry;
    logic       ovf;

    assign shamt  = b[3:0];
    assign sign_a = a[W-1];
    assign sign_b = b[W-1];
    assign sign_r = result[W-1];

    // Last bit shifted out; both stay 0 for a zero shift amount.
    always_comb begin
        shl_out = 1'b0;
        shr_out = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if ((int'(shamt) == i) && (i <= W)) begin
                shl_out = a[W-i];
                shr_out = a[i-1];
            end
        end
    end

    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        case (flag_class(op))
            FC_ADD: begin
                // a + b overflows W bits exactly when a exceeds the complement of b.
                carry = a > ~b;
                ovf   = (sign_a == sign_b) && (sign_r != sign_a);
            end
            FC_SUB: begin
                carry = a < b;
                ovf   = (sign_a != sign_b) && (sign_r != sign_a);
            end
            FC_SHL:  carry = shl_out;
            FC_SHR:  carry = shr_out;
            default: begin
                carry = 1'b0;
                ovf   = 1'b0;
            end
        endcase
    end

    always_comb begin
        flags        = 4'b0000;
        flags[FLG_S] = sign_r;
        flags[FLG_Z] = (result == '0);
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
    end

endmodule

// File: rtl/flag_gen.sv
// Two-stage condition-flag pipeline: captures flag-writing instructions into
// stage 1 and commits their computed flags into the architectural cond register.
module flag_gen
    import simple_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] result,
    input  logic         stall,
    input  logic         flush,
    output logic [3:0]   cond,
    output logic         busy
);

    logic         s1_valid;
    logic [3:0]   s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [W-1:0] s1_result;
    logic [3:0]   cond_q;
    logic [3:0]   s1_flags;
    logic         accept;
    logic         commit;

    // Handshake: there is no ready. An instruction is taken only when in_valid
    // is high with a flag-writing op and neither stall nor flush is asserted;
    // anything else presented that cycle is dropped, never held for later.
    assign accept = in_valid && is_flag_op(op) && !stall && !flush;
    assign commit = s1_valid && !stall && !flush;

    flag_calc #(.W(W)) u_flag_calc (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (s1_result),
        .flags  (s1_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_result <= '0;
            cond_q    <= 4'b0000;
        end else begin
            if (commit) begin
                cond_q <= s1_flags;
            end
            // Flush wins over stall; a stall freezes stage 1 entirely.
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (!stall) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_op     <= op;
                s1_a      <= a;
                s1_b      <= b;
                s1_result <= result;
            end
        end
    end

    assign cond = cond_q;
    assign busy = s1_valid;

endmodule
